// File: rtl/dm_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter and its byte-merge helper.
// Imported by the arbiter top and the merge sub-module.
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_MERGE = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational per-byte select between an existing word and new store data.
// Also used for sub-word store support in the memory-access stage.
module dm_byte_merge
    import dm_arbiter_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0]        i_old,
    input  logic [DW-1:0]        i_new,
    input  logic [DW/BYTE_W-1:0] i_be,
    output logic [DW-1:0]        o_merged
);

    always_comb begin
        o_merged = i_old;
        for (int i = 0; i < DW / BYTE_W; i++) begin
            if (i_be[i]) begin
                o_merged[BYTE_W*i +: BYTE_W] = i_new[BYTE_W*i +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single-port data memory; partial writes are
// performed as read-modify-write because the memory only has a word write enable.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            c_req,
    input  logic            c_we,
    input  logic [AW-1:0]   c_addr,
    input  logic [DW-1:0]   c_wdata,
    input  logic [DW/8-1:0] c_be,
    output logic            c_ack,
    output logic [DW-1:0]   c_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_ack,
    output logic [DW-1:0]   d_rdata,
    output logic            dm_we,
    output logic [AW-1:0]   dm_addr,
    output logic [DW-1:0]   dm_din,
    input  logic [DW-1:0]   dm_dout,
    output logic            busy
);

    localparam int            BW        = DW / 8;
    localparam logic [BW-1:0] BE_FULL   = '1;
    localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

    state_t          r_state;
    state_t          w_state_nxt;
    owner_t          r_owner;
    owner_t          r_last_owner;
    owner_t          w_grant_owner;
    logic            w_grant;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [BW-1:0]   r_be;
    logic [DW-1:0]   r_merge_q;
    logic [DW-1:0]   r_c_rdata;
    logic [DW-1:0]   r_d_rdata;
    logic [DW-1:0]   w_merged;

    dm_byte_merge #(.DW(DW)) u_merge (
        .i_old    (dm_dout),
        .i_new    (r_wdata),
        .i_be     (r_be),
        .o_merged (w_merged)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_grant       = 1'b0;
        w_grant_owner = OWN_C;
        dm_we         = 1'b0;
        dm_addr       = '0;
        dm_din        = '0;
        case (r_state)
            ST_IDLE: begin
                // On a tie, round-robin hands the slot to whoever did not go last.
                if (c_req && d_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = ((FIXED_PRIO != 0) || (r_last_owner == OWN_D)) ? OWN_C : OWN_D;
                end else if (c_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = OWN_C;
                end else if (d_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = OWN_D;
                end
                if (w_grant) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                dm_addr     = r_addr;
                w_state_nxt = ST_ACK;
                if (r_we) begin
                    if (r_be == BE_FULL) begin
                        dm_we  = 1'b1;
                        dm_din = r_wdata;
                    end else if (r_be != '0) begin
                        w_state_nxt = ST_MERGE;
                    end
                end
            end
            ST_MERGE: begin
                dm_addr     = r_addr;
                dm_we       = 1'b1;
                dm_din      = r_merge_q;
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_C;
            r_last_owner <= OWN_D;
            r_c_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_grant_owner;
            end
            if (r_state == ST_XFER && !r_we) begin
                if (r_owner == OWN_C) begin
                    r_c_rdata <= dm_dout;
                end else begin
                    r_d_rdata <= dm_dout;
                end
            end
            if (r_state == ST_ACK) begin
                r_last_owner <= r_owner;
            end
        end
    end

    // Transaction payload is only consumed while busy, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (w_grant) begin
            if (w_grant_owner == OWN_C) begin
                r_we    <= c_we;
                r_addr  <= c_addr & WORD_MASK;
                r_wdata <= c_wdata;
                r_be    <= c_be;
            end else begin
                r_we    <= d_we;
                r_addr  <= d_addr & WORD_MASK;
                r_wdata <= d_wdata;
                r_be    <= d_be;
            end
        end
        if (r_state == ST_XFER) begin
            r_merge_q <= w_merged;
        end
    end

    assign c_ack   = (r_state == ST_ACK) && (r_owner == OWN_C);
    assign d_ack   = (r_state == ST_ACK) && (r_owner == OWN_D);
    assign c_rdata = r_c_rdata;
    assign d_rdata = r_d_rdata;
    assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed transactions push expected acks,
// a negedge monitor pops and compares whenever an ack appears.
module tb_dm_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  c_be = '0, d_be = '0;
    logic        c_ack, d_ack, dm_we, busy;
    logic [31:0] c_rdata, d_rdata, dm_addr, dm_din, dm_dout;

    logic        b_c_req = 1'b0, b_d_req = 1'b0;
    logic        b_c_ack, b_d_ack, b_dm_we, b_busy;
    logic [31:0] b_c_rdata, b_d_rdata, b_dm_addr, b_dm_din;

    logic [31:0] mem [0:127];
    int          checks = 0;
    int          errors = 0;
    int          we_cnt = 0;
    logic [31:0] seen_addr = '0;

    typedef struct {
        logic        owner;
        logic        is_rd;
        logic [31:0] rdata;
    } exp_t;
    exp_t q[$];

    always #5 CLK = ~CLK;

    dm_arbiter #(.DW(32), .AW(32), .FIXED_PRIO(0)) dut (
        .CLK(CLK), .RST(RST),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout), .busy(busy)
    );

    dm_arbiter #(.DW(32), .AW(32), .FIXED_PRIO(1)) dut_prio (
        .CLK(CLK), .RST(RST),
        .c_req(b_c_req), .c_we(1'b0), .c_addr(32'h0), .c_wdata(32'h0), .c_be(4'h0),
        .c_ack(b_c_ack), .c_rdata(b_c_rdata),
        .d_req(b_d_req), .d_we(1'b0), .d_addr(32'h4), .d_wdata(32'h0), .d_be(4'h0),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_din(b_dm_din), .dm_dout(32'h5A5A5A5A),
        .busy(b_busy)
    );

    assign dm_dout = mem[dm_addr[8:2]];

    always @(posedge CLK) begin
        if (dm_we) begin
            mem[dm_addr[8:2]] <= dm_din;
            we_cnt <= we_cnt + 1;
        end
        if (busy && !c_ack && !d_ack) seen_addr <= dm_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ack(input logic owner, input logic is_rd, input logic [31:0] rdata);
        exp_t e;
        e.owner = owner;
        e.is_rd = is_rd;
        e.rdata = rdata;
        q.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RST && (c_ack || d_ack)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got c_ack=%b d_ack=%b expected none", c_ack, d_ack);
            end else begin
                e = q.pop_front();
                chk("ack_onehot", {31'b0, c_ack & d_ack}, 32'h0);
                chk("ack_owner", {31'b0, d_ack}, {31'b0, e.owner});
                if (e.is_rd) chk("rdata", d_ack ? d_rdata : c_rdata, e.rdata);
            end
        end
    end

    task automatic drive(input logic who, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        @(posedge CLK); #1;
        if (who == 1'b0) begin
            c_we = we; c_addr = addr; c_wdata = wdata; c_be = be; c_req = 1'b1;
        end else begin
            d_we = we; d_addr = addr; d_wdata = wdata; d_be = be; d_req = 1'b1;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            if ((who == 1'b0 && c_ack) || (who == 1'b1 && d_ack)) got = 1'b1;
            else begin
                @(posedge CLK);
                lat++;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack for requester %0d expected one", who);
            lat = -1;
        end
        @(posedge CLK); #1;
        if (who == 1'b0) c_req = 1'b0;
        else d_req = 1'b0;
    endtask

    initial begin
        int lat, w0, lat_c, lat_d;
        logic got;
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[32'h40 >> 2]  = 32'hDEADBEEF;
        mem[32'h10 >> 2]  = 32'hAABBCCDD;
        mem[32'h14 >> 2]  = 32'h01020304;
        mem[32'h40 >> 2]  = 32'hDEADBEEF;
        mem[32'h100 >> 2] = 32'h11110000;
        mem[32'h104 >> 2] = 32'h22220000;
        mem[32'h108 >> 2] = 32'h33330000;
        mem[32'h10C >> 2] = 32'h44440000;

        #1;
        chk("rst_c_ack", {31'b0, c_ack}, 32'h0);
        chk("rst_d_ack", {31'b0, d_ack}, 32'h0);
        chk("rst_rdata", c_rdata | d_rdata, 32'h0);
        chk("rst_dm_we", {31'b0, dm_we}, 32'h0);
        chk("rst_dm_addr_din", dm_addr | dm_din, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;

        // C read alone
        w0 = we_cnt;
        expect_ack(1'b0, 1'b1, 32'hDEADBEEF);
        drive(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, lat);
        chk("read_latency", lat, 2);
        chk("read_no_we", we_cnt - w0, 0);
        chk("rdata_hold", c_rdata, 32'hDEADBEEF);

        // D full write then C read back
        w0 = we_cnt;
        expect_ack(1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h80, 32'h12345678, 4'hF, lat);
        chk("full_wr_latency", lat, 2);
        chk("full_wr_we_pulses", we_cnt - w0, 1);
        chk("full_wr_mem", mem[32'h80 >> 2], 32'h12345678);
        expect_ack(1'b0, 1'b1, 32'h12345678);
        drive(1'b0, 1'b0, 32'h80, 32'h0, 4'h0, lat);

        // partial writes through MERGE
        w0 = we_cnt;
        expect_ack(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h10, 32'h00000011, 4'b0001, lat);
        chk("part_wr_latency", lat, 3);
        chk("part_wr_we_pulses", we_cnt - w0, 1);
        chk("part_wr_mem", mem[32'h10 >> 2], 32'hAABBCC11);
        expect_ack(1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h10, 32'h11223344, 4'b1010, lat);
        chk("part_wr2_mem", mem[32'h10 >> 2], 32'h11BB3311);

        // be=0 write to a misaligned address
        w0 = we_cnt;
        expect_ack(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h43, 32'hFFFFFFFF, 4'h0, lat);
        chk("be0_latency", lat, 2);
        chk("be0_no_we", we_cnt - w0, 0);
        chk("be0_xfer_addr", seen_addr, 32'h40);
        chk("be0_mem", mem[32'h40 >> 2], 32'hDEADBEEF);

        // round-robin with both requesters active, fresh reset so C wins first
        @(negedge CLK) RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
        expect_ack(1'b0, 1'b1, 32'h11110000);
        expect_ack(1'b1, 1'b1, 32'h33330000);
        expect_ack(1'b0, 1'b1, 32'h22220000);
        expect_ack(1'b1, 1'b1, 32'h44440000);
        fork
            begin
                drive(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, lat_c);
                drive(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, lat_c);
            end
            begin
                drive(1'b1, 1'b0, 32'h108, 32'h0, 4'h0, lat_d);
                drive(1'b1, 1'b0, 32'h10C, 32'h0, 4'h0, lat_d);
            end
        join

        // tie after C went last: D must win
        expect_ack(1'b0, 1'b1, 32'h11110000);
        drive(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, lat);
        expect_ack(1'b1, 1'b1, 32'h22220000);
        expect_ack(1'b0, 1'b1, 32'h33330000);
        fork
            drive(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, lat_d);
            drive(1'b0, 1'b0, 32'h108, 32'h0, 4'h0, lat_c);
        join
        chk("tie_d_latency", lat_d, 2);

        // reset during MERGE aborts the write
        @(posedge CLK); #1;
        c_we = 1'b1; c_addr = 32'h14; c_wdata = 32'hFFFFFFFF; c_be = 4'b0011; c_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            if (dm_we) got = 1'b1;
        end
        chk("merge_we_seen", {31'b0, got}, 32'h1);
        RST = 1'b1;
        #1;
        chk("abort_dm_we", {31'b0, dm_we}, 32'h0);
        chk("abort_acks", {30'b0, c_ack, d_ack}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        c_req = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("abort_mem", mem[32'h14 >> 2], 32'h01020304);
        @(negedge CLK) RST = 1'b0;
        expect_ack(1'b0, 1'b1, 32'h01020304);
        drive(1'b0, 1'b0, 32'h14, 32'h0, 4'h0, lat);

        // fixed-priority instance: C wins a tie even right after C was served
        @(posedge CLK); #1;
        b_c_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            if (b_c_ack) got = 1'b1;
        end
        chk("prio_first_ack", {31'b0, got}, 32'h1);
        chk("prio_rdata", b_c_rdata, 32'h5A5A5A5A);
        @(posedge CLK); #1;
        b_c_req = 1'b0;
        @(posedge CLK); #1;
        b_c_req = 1'b1;
        b_d_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            if (b_c_ack || b_d_ack) got = 1'b1;
        end
        chk("prio_tie_winner", {30'b0, b_c_ack, b_d_ack}, 32'h2);
        @(posedge CLK); #1;
        b_c_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge CLK);
            if (b_d_ack || b_c_ack) got = 1'b1;
        end
        chk("prio_then_d", {30'b0, b_c_ack, b_d_ack}, 32'h1);
        @(posedge CLK); #1;
        b_d_req = 1'b0;

        repeat (4) @(posedge CLK);
        chk("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
